capture_ctrl: RTL and testbench
===============================

Name: capture_ctrl

Overview:
- Sequences one oscilloscope capture into the 256-entry sample RAM.
- Divides the 50 MHz clock to produce the ADC sample strobe and fills pre-trigger history.
- Detects a level/edge trigger, completes the post-trigger fill, then reports done plus the oldest-sample address for the sample reader.
- Sits between the top-level state watcher (activate/done handshake), the ADC and the sample RAM write port.

Parameters:
- DATA_WIDTH, 8, ADC sample / RAM word width
- ADDR_WIDTH, 8, RAM address width; DEPTH = 2**ADDR_WIDTH
- DIV_WIDTH, 16, sample-rate divider width
- AUTO_TIMEOUT, 1024, samples spent in WAIT_TRIG before a forced trigger (used only with CAPTURE_AUTO_TRIG_EN)

Ports:
- clk_50mhz  in  1  system clock
- reset  in  1  synchronous, active-high reset
- activate  in  1  level; high = run capture, low = abort/idle
- done  out  1  capture complete; held until activate falls
- busy  out  1  high in PRE, WAIT_TRIG and POST
- triggered  out  1  trigger seen in the current capture
- trig_level  in  DATA_WIDTH  trigger threshold (unsigned)
- trig_rising  in  1  1 = rising edge, 0 = falling edge
- pretrig  in  ADDR_WIDTH  samples kept before the trigger
- clk_div  in  DIV_WIDTH  sample period = max(clk_div,1)+1 cycles
- adc_clk  out  1  ADC conversion clock
- adc_data  in  DATA_WIDTH  ADC sample
- mem_data  out  DATA_WIDTH  RAM write data
- mem_addr  out  ADDR_WIDTH  RAM write address
- mem_we  out  1  RAM write enable, one-cycle pulse
- start_addr  out  ADDR_WIDTH  address of the oldest sample; valid while done=1
- auto_fired  out  1  trigger was forced by timeout

Behaviour:
- Reset: state IDLE. All outputs 0: done, busy, triggered, adc_clk, mem_*, start_addr, auto_fired. Divider, write pointer (wr_ptr) and counters cleared.
- Config latch: trig_level, trig_rising, pretrig and clk_div are latched on the IDLE->active transition. Later changes to these inputs are ignored until the next capture.
- Divider: div_cnt counts 0..P-1, with P = max(clk_div,1)+1.
  - adc_clk = 1 while div_cnt < P/2 (integer division), else 0.
  - The sample strobe fires on the cycle div_cnt == P-1.
  - The divider runs only while busy; it restarts at 0 on entering PRE.
- Write: on strobe, mem_data <= adc_data, mem_addr <= wr_ptr and mem_we <= 1, all registered, so the write is visible the cycle after the strobe. wr_ptr then increments mod DEPTH. mem_we is never high for two consecutive cycles.
- IDLE:
  - activate=1 -> PRE if latched pretrig > 0.
  - activate=1 -> WAIT_TRIG if latched pretrig = 0.
  - wr_ptr resets to 0 on this transition.
- PRE: counts strobes; after the pretrig-th write -> WAIT_TRIG.
- WAIT_TRIG:
  - Writes continue; the buffer wraps freely.
  - Trigger on sample s with previous sample p:
    - rising: p < trig_level and s >= trig_level.
    - falling: p > trig_level and s <= trig_level.
  - p is invalid for the first sample after activate, so that sample can never trigger.
  - A trigger can also occur on the last PRE sample's successor, i.e. the first WAIT_TRIG sample.
  - On trigger: the triggering sample is written, trig_addr <= its address, triggered <= 1, then -> POST.
- POST:
  - The trigger sample counts as post-sample 1.
  - After DEPTH - pretrig post-samples, the state is DONE.
  - Example: pretrig=0 gives 256 post-samples.
- DONE:
  - busy=0, done=1, adc_clk=0, no writes.
  - start_addr = (trig_addr - pretrig) mod DEPTH.
  - activate=0 -> IDLE next cycle; done and triggered clear.
- Abort: activate=0 in PRE, WAIT_TRIG or POST -> IDLE next cycle. A write already registered completes; no further writes; done stays 0.
- Reset mid-capture: same as the reset values, regardless of state.
- activate high immediately after DONE->IDLE starts a new capture.

Optional Feature:
- Macro: CAPTURE_AUTO_TRIG_EN
- Defined:
  - A counter counts strobes in WAIT_TRIG.
  - When AUTO_TIMEOUT samples pass with no trigger, the next sample is the trigger sample.
  - triggered=1 and auto_fired=1 are set; auto_fired is held until IDLE.
  - The counter clears on entering WAIT_TRIG.
- Undefined: no counter is built; auto_fired is tied to 0; WAIT_TRIG waits indefinitely.

Test Plan:
- Reset check: reset=1 for 3 cycles with activate=1 -> all outputs 0, no mem_we.
- Rising trigger, basic capture:
  - Stimulus: clk_div=3, pretrig=16, trig_level=0x80, rising; adc ramp 0x00,0x01,... incrementing per strobe.
  - Required: first mem_we at addr 0, writes spaced exactly 4 cycles apart.
  - Required: trigger at sample 0x80 (addr 0x80); done after 240 post-samples; start_addr=0x70.
- Falling trigger and pretrig=0:
  - Stimulus: constant 0xFF for 10 samples, then 0x10.
  - Required: trigger on the 0x10 sample, addr 10; 256 writes after the trigger; start_addr=10.
- Abort: drop activate in WAIT_TRIG -> IDLE next cycle, no further mem_we, done=0. Re-assert -> new capture restarts at addr 0.
- No-trigger wrap (macro off): constant 0x40, level 0x80 for 600 samples.
  - Required: wr_ptr wraps 255->0, busy stays 1, triggered=0.
- Auto trigger (CAPTURE_AUTO_TRIG_EN, AUTO_TIMEOUT=8), constant input:
  - Required: forced trigger on the 9th WAIT_TRIG sample, auto_fired=1.
  - Required: done after DEPTH-pretrig post-samples.

Source files
------------

// File: rtl/capture_ctrl_if.sv
// Bus bundle between capture_ctrl and its environment: state-watcher handshake,
// trigger configuration, ADC sample input, RAM write port and an FSM debug view.
interface capture_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
);
    // Handshake: activate is a level request. done rises once the capture completes
    // and is held until activate falls. Dropping activate earlier aborts the capture.
    logic                  activate;
    logic                  done;
    logic                  busy;
    logic                  triggered;
    logic [DATA_WIDTH-1:0] trig_level;
    logic                  trig_rising;
    logic [ADDR_WIDTH-1:0] pretrig;
    logic [DIV_WIDTH-1:0]  clk_div;
    logic                  adc_clk;
    logic [DATA_WIDTH-1:0] adc_data;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  auto_fired;
    logic [2:0]            fsm_state;

    modport slave (
        input  activate, trig_level, trig_rising, pretrig, clk_div, adc_data,
        output done, busy, triggered, adc_clk, mem_data, mem_addr, mem_we,
               start_addr, auto_fired, fsm_state
    );

    modport master (
        output activate, trig_level, trig_rising, pretrig, clk_div, adc_data,
        input  done, busy, triggered, adc_clk, mem_data, mem_addr, mem_we,
               start_addr, auto_fired, fsm_state
    );
endinterface

// File: rtl/capture_ctrl.sv
// Single-shot oscilloscope capture sequencer: ADC strobe divider, pre-trigger fill,
// edge trigger, post-trigger fill. Optional timeout trigger: CAPTURE_AUTO_TRIG_EN.
module capture_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int DIV_WIDTH    = 16,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic           clk_50mhz,
    input  logic           reset,
    capture_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] lvl;
    logic                  rising;
    logic [ADDR_WIDTH-1:0] pre_n;
    logic [DIV_WIDTH:0]    per;
    logic [DIV_WIDTH:0]    div_cnt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   cnt_inc;
    logic [ADDR_WIDTH:0]   post_need;
    logic [DATA_WIDTH-1:0] prev;
    logic                  prev_valid;
    logic [ADDR_WIDTH-1:0] trig_addr;
    logic                  triggered_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_we_q;
    logic                  busy_c;
    logic                  strobe;
    logic                  natural;
    logic                  forced;
    logic                  trig_hit;

    assign busy_c    = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    assign strobe    = busy_c && bus.activate && (div_cnt == per - 1'b1);
    assign cnt_inc   = cnt + 1'b1;
    // The trigger sample plus the rest of the post fill make up DEPTH - pretrig samples.
    assign post_need = {1'b1, {ADDR_WIDTH{1'b0}}} - {1'b0, pre_n};

    always_comb begin
        natural = 1'b0;
        if (prev_valid) begin
            if (rising) natural = (prev < lvl) && (bus.adc_data >= lvl);
            else        natural = (prev > lvl) && (bus.adc_data <= lvl);
        end
    end

`ifdef CAPTURE_AUTO_TRIG_EN
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);
    logic [TW-1:0] auto_cnt;
    logic          auto_q;
    assign forced         = (auto_cnt == TW'(AUTO_TIMEOUT));
    assign bus.auto_fired = auto_q;
`else
    localparam int unused_auto_timeout = AUTO_TIMEOUT;
    assign forced         = 1'b0;
    assign bus.auto_fired = 1'b0;
`endif

    assign trig_hit = strobe && (state == S_WAIT) && (natural || forced);

    always_ff @(posedge clk_50mhz) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.activate) state_nxt = (bus.pretrig != '0) ? S_PRE : S_WAIT;
            S_PRE: begin
                if (!bus.activate)                                state_nxt = S_IDLE;
                else if (strobe && (cnt_inc == {1'b0, pre_n}))    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.activate) state_nxt = S_IDLE;
                else if (trig_hit)
                    state_nxt = (post_need == (ADDR_WIDTH+1)'(1)) ? S_DONE : S_POST;
            end
            S_POST: begin
                if (!bus.activate)                       state_nxt = S_IDLE;
                else if (strobe && (cnt_inc == post_need)) state_nxt = S_DONE;
            end
            S_DONE:  if (!bus.activate) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            lvl         <= '0;
            rising      <= 1'b0;
            pre_n       <= '0;
            per         <= '0;
            div_cnt     <= '0;
            wr_ptr      <= '0;
            cnt         <= '0;
            prev        <= '0;
            prev_valid  <= 1'b0;
            trig_addr   <= '0;
            triggered_q <= 1'b0;
            mem_data_q  <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
            auto_cnt    <= '0;
            auto_q      <= 1'b0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            if (state == S_IDLE || !bus.activate) begin
                div_cnt     <= '0;
                cnt         <= '0;
                prev_valid  <= 1'b0;
                triggered_q <= 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
                auto_cnt    <= '0;
                auto_q      <= 1'b0;
`endif
                if (state == S_IDLE && bus.activate) begin
                    lvl    <= bus.trig_level;
                    rising <= bus.trig_rising;
                    pre_n  <= bus.pretrig;
                    per    <= ((bus.clk_div == '0) ? (DIV_WIDTH+1)'(1) : {1'b0, bus.clk_div}) + 1'b1;
                    wr_ptr <= '0;
                end
            end else if (busy_c) begin
                div_cnt <= strobe ? '0 : div_cnt + 1'b1;
`ifdef CAPTURE_AUTO_TRIG_EN
                if (state == S_PRE) auto_cnt <= '0;
`endif
                if (strobe) begin
                    mem_data_q <= bus.adc_data;
                    mem_addr_q <= wr_ptr;
                    mem_we_q   <= 1'b1;
                    wr_ptr     <= wr_ptr + 1'b1;
                    prev       <= bus.adc_data;
                    prev_valid <= 1'b1;
                    case (state)
                        S_PRE:  cnt <= (cnt_inc == {1'b0, pre_n}) ? '0 : cnt_inc;
                        S_WAIT: begin
                            if (trig_hit) begin
                                trig_addr   <= wr_ptr;
                                triggered_q <= 1'b1;
                                cnt         <= (ADDR_WIDTH+1)'(1);
`ifdef CAPTURE_AUTO_TRIG_EN
                                auto_q      <= forced && !natural;
                            end else begin
                                auto_cnt    <= auto_cnt + 1'b1;
`endif
                            end
                        end
                        S_POST:  cnt <= cnt_inc;
                        default: cnt <= cnt;
                    endcase
                end
            end
        end
    end

    assign bus.done       = (state == S_DONE);
    assign bus.busy       = busy_c;
    assign bus.triggered  = triggered_q;
    assign bus.adc_clk    = busy_c && (div_cnt < (per >> 1));
    assign bus.mem_data   = mem_data_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.start_addr = (state == S_DONE) ? (trig_addr - pre_n) : '0;
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: directed and random captures checked against a
// sample-list model of the capture (trigger index, write list, start address).
module tb_capture_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DVW   = 16;
  localparam int TMO   = 8;
  localparam int DEPTH = 256;
  localparam int NSAMP = 4096;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [DW+AW-1:0] exp_q[$];
  logic [DW-1:0]    samp[NSAMP];

  always #10 clk = ~clk;

  capture_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIV_WIDTH(DVW)) bus ();

  capture_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIV_WIDTH(DVW), .AUTO_TIMEOUT(TMO)
  ) dut (
    .clk_50mhz(clk),
    .reset    (rst),
    .bus      (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_trig"}, bus.triggered, 0);
    check({tag, "_adc_clk"}, bus.adc_clk, 0);
    check({tag, "_mem_we"}, bus.mem_we, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_data"}, bus.mem_data, 0);
    check({tag, "_start"}, bus.start_addr, 0);
    check({tag, "_auto"}, bus.auto_fired, 0);
  endtask

  // mode 0 ramp, 1 ten 0xFF then 0x10, 2 constant 0x40, 3 random
  task automatic fill(input int mode);
    for (int i = 0; i < NSAMP; i++) begin
      case (mode)
        0:       samp[i] = 8'(i % 256);
        1:       samp[i] = (i < 10) ? 8'hFF : 8'h10;
        2:       samp[i] = 8'h40;
        default: samp[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // abort_after > 0: drop activate once that many writes were seen.
  task automatic run_capture(input int pre, input int div, input int lvl, input bit rise,
                             input int abort_after);
    int per, tidx, total, nw, hi, last_cyc, limit, cyc;
    bit auto_exp, nat;
    logic [DW+AW-1:0] e;
    per = ((div == 0) ? 1 : div) + 1;
    tidx = -1;
    auto_exp = 1'b0;
    for (int i = pre; i < 1700 && tidx < 0; i++) begin
      nat = (i >= 1) && (rise ? (samp[i-1] < lvl && samp[i] >= lvl)
                              : (samp[i-1] > lvl && samp[i] <= lvl));
      if (nat) tidx = i;
`ifdef CAPTURE_AUTO_TRIG_EN
      else if (i == pre + TMO) begin
        tidx = i;
        auto_exp = 1'b1;
      end
`endif
    end
    total = (tidx < 0) ? 1700 : tidx + DEPTH - pre;
    if (abort_after > 0 && abort_after < total) total = abort_after;
    exp_q.delete();
    for (int i = 0; i < total; i++) exp_q.push_back({8'(i % DEPTH), samp[i]});

    bus.trig_level  = 8'(lvl);
    bus.trig_rising = rise;
    bus.pretrig     = 8'(pre);
    bus.clk_div     = 16'(div);
    bus.adc_data    = samp[0];
    bus.activate    = 1'b1;
    @(posedge clk);
    #1;
    // configuration must be ignored once latched
    bus.trig_level  = 8'($urandom_range(0, 255));
    bus.trig_rising = ~rise;
    bus.pretrig     = 8'($urandom_range(0, 255));
    bus.clk_div     = 16'($urandom_range(0, 9));

    nw = 0; hi = 0; last_cyc = 0;
    limit = total * per + 40;
    for (cyc = 0; cyc < limit; cyc++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        if (exp_q.size() == 0) check("extra_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", bus.mem_addr, e[15:8]);
          check("wr_data", bus.mem_data, e[7:0]);
        end
        if (nw > 0) begin
          check("wr_spacing", cyc - last_cyc, per);
          check("adc_clk_duty", hi, per / 2);
        end
        last_cyc = cyc;
        hi = 0;
        nw++;
        bus.adc_data = samp[nw];
      end
      hi += int'(bus.adc_clk);
      if (abort_after > 0 && nw == abort_after) break;
      if (bus.done) break;
    end

    if (abort_after > 0 && nw == abort_after && total == abort_after) begin
      check("pre_abort_busy", bus.busy, 1);
      check("pre_abort_trig", bus.triggered, (tidx >= 0 && nw > tidx) ? 1 : 0);
      check("pre_abort_done", bus.done, 0);
      bus.activate = 1'b0;
      @(negedge clk);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_trig", bus.triggered, 0);
      nw = 0;
      for (int c = 0; c < 3 * per + 4; c++) begin
        @(negedge clk);
        nw += int'(bus.mem_we);
      end
      check("abort_writes", nw, 0);
    end else begin
      check("done_seen", bus.done, 1);
      check("left_expected", exp_q.size(), 0);
      check("start_addr", bus.start_addr, ((tidx - pre) % DEPTH + DEPTH) % DEPTH);
      check("done_trig", bus.triggered, 1);
      check("done_busy", bus.busy, 0);
      check("auto_fired", bus.auto_fired, auto_exp);
      @(negedge clk);
      check("done_hold", bus.done, 1);
      check("done_adc_clk", bus.adc_clk, 0);
      check("done_we", bus.mem_we, 0);
      bus.activate = 1'b0;
      @(negedge clk);
      check("release_done", bus.done, 0);
      check("release_trig", bus.triggered, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.activate = 1'b1;
    bus.trig_level = 8'h80;
    bus.trig_rising = 1'b1;
    bus.pretrig = 8'd4;
    bus.clk_div = 16'd1;
    bus.adc_data = 8'h00;
    repeat (3) begin
      @(negedge clk);
      check_idle("reset");
    end
    bus.activate = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    fill(0);
    run_capture(16, 3, 8'h80, 1'b1, 0);
    fill(1);
    run_capture(0, 2, 8'h80, 1'b0, 0);
    fill(2);
    run_capture(4, 2, 8'h80, 1'b1, 12);
    fill(0);
    run_capture(3, 1, 8'h20, 1'b1, 0);
`ifdef CAPTURE_AUTO_TRIG_EN
    fill(2);
    run_capture(5, 1, 8'h80, 1'b1, 0);
    run_capture(0, 0, 8'h80, 1'b0, 0);
`else
    fill(2);
    run_capture(8, 1, 8'h80, 1'b1, 600);
`endif
    fill(3);
    run_capture(255, 0, 8'h80, 1'b1, 0);
    for (int r = 0; r < 6; r++) begin
      fill(3);
      run_capture($urandom_range(0, 40), $urandom_range(0, 3), $urandom_range(1, 254),
                  1'($urandom_range(0, 1)), 0);
    end

    fill(0);
    bus.trig_level = 8'hF0;
    bus.trig_rising = 1'b1;
    bus.pretrig = 8'd2;
    bus.clk_div = 16'd1;
    bus.activate = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid_reset");
    bus.activate = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_mid_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
